// File: rtl/shader_instr_ring_pkg.sv
// Shared shader types: instruction width, instruction type and the NOP encoding
// used to fill the reset program.
package shader_pkg;
  localparam int INSTR_WIDTH = 8;
  typedef logic [INSTR_WIDTH-1:0] instr_t;
  localparam instr_t INSTR_NOP = 8'h00;
endpackage

// File: rtl/shader_instr_ring_if.sv
// Handshake bundle between the SPI stage / execution unit and the instruction ring.
interface shader_instr_ring_if
  import shader_pkg::*;
#(
  parameter int NUM_INSTR = 8
);
  localparam int PC_W = $clog2(NUM_INSTR);

  instr_t            spi_instr_i;
  logic              spi_shift_i;
  logic              spi_load_i;
  logic              hold_i;
  logic              exec_shift_i;
  instr_t            instr_o;
  logic [PC_W-1:0]   pc_o;
  logic              last_o;
  logic              wrap_o;
  logic              prog_loaded_o;

  modport master (
    output spi_instr_i, spi_shift_i, spi_load_i, hold_i, exec_shift_i,
    input  instr_o, pc_o, last_o, wrap_o, prog_loaded_o
  );

  modport slave (
    input  spi_instr_i, spi_shift_i, spi_load_i, hold_i, exec_shift_i,
    output instr_o, pc_o, last_o, wrap_o, prog_loaded_o
  );
endinterface

// File: rtl/shader_instr_ring.sv
// Shader program store as a circular shift register: head feeds execution, tail
// accepts SPI program bytes; pc and load counter track the logical position.
module shader_instr_ring
  import shader_pkg::*;
#(
  parameter int NUM_INSTR = 8,
  parameter logic [NUM_INSTR*INSTR_WIDTH-1:0] DEFAULT_PROGRAM = {NUM_INSTR{INSTR_NOP}}
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  shader_instr_ring_if.slave ring
);
  localparam int PC_W = $clog2(NUM_INSTR);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(NUM_INSTR - 1);

  logic [NUM_INSTR-1:0][INSTR_WIDTH-1:0] ring_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] load_cnt_q;
  logic            wrap_q;
  logic            prog_loaded_q;

  // SPI and exec shifting together still yield a single rotation.
  logic   shift;
  logic   load;
  instr_t tail_in;

  assign shift   = ring.spi_shift_i | (ring.exec_shift_i & ~ring.hold_i);
  assign load    = ring.spi_load_i & ring.spi_shift_i;
  assign tail_in = load ? ring.spi_instr_i : ring_q[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_q        <= DEFAULT_PROGRAM;
      pc_q          <= '0;
      load_cnt_q    <= '0;
      wrap_q        <= 1'b0;
      prog_loaded_q <= 1'b0;
    end else begin
      wrap_q        <= 1'b0;
      prog_loaded_q <= 1'b0;
      if (shift) begin
        ring_q <= {tail_in, ring_q[NUM_INSTR-1:1]};
        pc_q   <= pc_q + 1'b1;
        wrap_q <= (pc_q == PC_MAX);
      end
      if (load) begin
        load_cnt_q    <= load_cnt_q + 1'b1;
        prog_loaded_q <= (load_cnt_q == PC_MAX);
      end
    end
  end

  assign ring.instr_o       = ring_q[0];
  assign ring.pc_o          = pc_q;
  assign ring.last_o        = (pc_q == PC_MAX);
  assign ring.wrap_o        = wrap_q;
  assign ring.prog_loaded_o = prog_loaded_q;
endmodule

// File: tb/tb_shader_instr_ring.sv
// Directed bench for shader_instr_ring: exec rotation, hold, SPI program load,
// coincident shifts, stray load pulses and asynchronous reset mid-load.
module tb_shader_instr_ring;
  import shader_pkg::*;

  localparam int N = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  shader_instr_ring_if #(.NUM_INSTR(N)) ring_if ();

  shader_instr_ring #(
    .NUM_INSTR      (N),
    .DEFAULT_PROGRAM({8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00})
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ring  (ring_if.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end at a negedge; one posedge consumes the inputs.
  task automatic cyc(input logic sh, input logic ld, input logic ex, input logic [7:0] b);
    ring_if.spi_shift_i  = sh;
    ring_if.spi_load_i   = ld;
    ring_if.exec_shift_i = ex;
    ring_if.spi_instr_i  = b;
    @(negedge clk_i);
    ring_if.spi_shift_i  = 1'b0;
    ring_if.spi_load_i   = 1'b0;
    ring_if.exec_shift_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  initial begin
    ring_if.spi_instr_i  = '0;
    ring_if.spi_shift_i  = 1'b0;
    ring_if.spi_load_i   = 1'b0;
    ring_if.hold_i       = 1'b0;
    ring_if.exec_shift_i = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    idle(1);

    chk("rst_instr", 32'(ring_if.instr_o), 32'h00);
    chk("rst_pc", 32'(ring_if.pc_o), 32'd0);
    chk("rst_wrap", 32'(ring_if.wrap_o), 32'd0);
    chk("rst_loaded", 32'(ring_if.prog_loaded_o), 32'd0);
    chk("rst_last", 32'(ring_if.last_o), 32'd0);

    // Eight exec shifts walk the default program and wrap once.
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("exec_instr", 32'(ring_if.instr_o), 32'((k + 1) % N));
      chk("exec_pc", 32'(ring_if.pc_o), 32'((k + 1) % N));
      chk("exec_wrap", 32'(ring_if.wrap_o), 32'(k == N - 1));
      chk("exec_last", 32'(ring_if.last_o), 32'(k == N - 2));
    end
    idle(1);
    chk("wrap_1cyc", 32'(ring_if.wrap_o), 32'd0);

    // Held exec requests must not move anything.
    ring_if.hold_i = 1'b1;
    ring_if.exec_shift_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      chk("hold_state", {16'h0, ring_if.instr_o, 5'h0, ring_if.pc_o, ring_if.wrap_o}, 32'h0);
    end
    ring_if.exec_shift_i = 1'b0;

    // Program load A0..A7, 16 cycles apart.
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(k));
      chk("ld_pc", 32'(ring_if.pc_o), 32'((k + 1) % N));
      chk("ld_loaded", 32'(ring_if.prog_loaded_o), 32'(k == N - 1));
      chk("ld_wrap", 32'(ring_if.wrap_o), 32'(k == N - 1));
      idle(15);
    end
    chk("ld_head", 32'(ring_if.instr_o), 32'hA0);
    chk("ld_loaded_clr", 32'(ring_if.prog_loaded_o), 32'd0);

    ring_if.hold_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("run_instr", 32'(ring_if.instr_o), 32'hA0 + 32'(k));
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
    end
    chk("run_pc", 32'(ring_if.pc_o), 32'd0);

    // Coincident SPI load and exec shift: one rotation, 5A into the tail.
    cyc(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("dual_pc", 32'(ring_if.pc_o), 32'd1);
    chk("dual_instr", 32'(ring_if.instr_o), 32'hA1);
    for (int k = 0; k < N - 1; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("dual_tail", 32'(ring_if.instr_o), 32'h5A);
    chk("dual_pc_wrap", 32'(ring_if.pc_o), 32'd0);

    // Load without shift is ignored; load_cnt is 1 here, so 7 more loads complete.
    cyc(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("stray_pc", 32'(ring_if.pc_o), 32'd0);
    chk("stray_instr", 32'(ring_if.instr_o), 32'h5A);
    ring_if.hold_i = 1'b1;
    for (int k = 0; k < N - 1; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(k));
      chk("b2b_loaded", 32'(ring_if.prog_loaded_o), 32'(k == N - 2));
    end

    // Partial load then asynchronous reset mid-cycle.
    cyc(1'b1, 1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b1, 1'b0, 8'h33);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_instr", 32'(ring_if.instr_o), 32'h00);
    chk("arst_pc", 32'(ring_if.pc_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'hC0 + 8'(k));
      chk("reld_loaded", 32'(ring_if.prog_loaded_o), 32'(k == N - 1));
    end
    chk("reld_pc", 32'(ring_if.pc_o), 32'd0);
    chk("reld_head", 32'(ring_if.instr_o), 32'hC0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/shader_instr_ring.md
Name: shader_instr_ring

Overview:
- Instruction store directly downstream of the SPI receiver stage.
- Holds the shader program as a ring of NUM_INSTR 8-bit instructions, implemented as a circular shift register.
- Presents the head instruction to the execution unit, which rotates the ring one step per executed instruction.
- The SPI stage writes a new program byte-by-byte through the tail of the same ring. Its shift and load pulses arrive together, and it writes one byte per 8 SCLK cycles.

Parameters:
- NUM_INSTR, 8, number of instruction slots; must be a power of two and >= 2.
- DEFAULT_PROGRAM, all-zero, NUM_INSTR*8 bits; reset contents, slot i = bits [8i+7:8i].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- spi_instr_i  in  8  instruction byte from the SPI stage
- spi_shift_i  in  1  single-cycle shift pulse from the SPI stage
- spi_load_i  in  1  single-cycle load pulse; always coincides with spi_shift_i
- hold_i  in  1  1 = execution stalled (SPI data mode); exec_shift_i is ignored
- exec_shift_i  in  1  advance one instruction (execution unit)
- instr_o  out  8  head instruction, slot 0
- pc_o  out  $clog2(NUM_INSTR)  logical index of the instruction at the head
- last_o  out  1  pc_o == NUM_INSTR-1 (combinational from pc_o)
- wrap_o  out  1  registered pulse: the ring completed one full rotation
- prog_loaded_o  out  1  registered pulse: NUM_INSTR bytes loaded since the last pulse or reset

Behaviour:
- Reset (async):
  - slot i <= DEFAULT_PROGRAM[8i+7:8i]
  - pc <= 0, load_cnt <= 0
  - wrap_o = 0, prog_loaded_o = 0
  - instr_o = DEFAULT_PROGRAM[7:0]
- Effective shift: shift = spi_shift_i | (exec_shift_i & ~hold_i).
  - Both sources active in the same cycle give exactly one rotation, not two.
- On a shift, in a single clock edge:
  - slot[i] <= slot[i+1] for i < NUM_INSTR-1.
  - slot[NUM_INSTR-1] <= (spi_load_i & spi_shift_i) ? spi_instr_i : slot[0].
  - A load overwrites the instruction leaving the head.
- spi_load_i without spi_shift_i is ignored: no state change.
- instr_o = slot[0], combinational from registers. The new head is visible the cycle after the shift edge (latency 1).
- pc: on each shift, pc <= pc + 1 mod NUM_INSTR (natural wrap of the power-of-two counter).
- wrap_o:
  - Set to 1 for exactly one cycle after a shift that moves pc from NUM_INSTR-1 to 0.
  - 0 otherwise.
- load_cnt, width $clog2(NUM_INSTR):
  - Increments on each load.
  - When a load occurs with load_cnt == NUM_INSTR-1: load_cnt wraps to 0 and prog_loaded_o pulses high for one cycle after that edge.
- Program alignment:
  - With hold_i=1 throughout and pc=0 at the start, NUM_INSTR loads leave the first loaded byte at the head, with pc=0.
  - Loads are not aligned to pc; loading begun with pc != 0 still rotates correctly. The program origin is then pc's value at the first load.
- No back-pressure. A shift every cycle is legal, including back-to-back loads.
- hold_i affects only exec_shift_i. SPI shifts proceed regardless.
- Reset mid-load: all state returns to reset values and the partial program is discarded.

Decomposition:
- Shared package shader_pkg holds:
  - INSTR_WIDTH = 8
  - the instruction typedef instr_t (logic [7:0])
  - INSTR_NOP constant, used to build DEFAULT_PROGRAM at the top level
- No sub-module. The ring, pc and load counter are a single always_ff, plus combinational output assigns.

Test Plan:
- Reset with DEFAULT_PROGRAM = {8'h07,...,8'h00} (slot i = i) -> instr_o=8'h00, pc_o=0. Then 8 exec shifts with hold_i=0 -> instr_o steps 00..07, back to 00. wrap_o pulses once after the 8th shift; last_o=1 while pc_o=7.
- hold_i=1, exec_shift_i=1 for 20 cycles -> instr_o, pc_o and the ring unchanged; wrap_o stays 0.
- hold_i=1, 8 SPI load+shift pulses with bytes A0..A7, spaced 16 cycles apart -> prog_loaded_o pulses once after the 8th, pc_o=0, instr_o=A0. Then 8 exec shifts with hold_i=0 read A0..A7 in order.
- Same cycle spi_shift_i=spi_load_i=1 (byte 5A) and exec_shift_i=1, hold_i=0 -> exactly one rotation, pc_o advances by 1, 5A lands in slot 7.
- spi_load_i=1 with spi_shift_i=0 -> no change to the ring, pc_o or load_cnt.
- After 3 of 8 loads (bytes 11,22,33), assert rst_ni=0 asynchronously mid-cycle -> outputs return immediately to DEFAULT_PROGRAM head and pc_o=0. After a subsequent full 8-byte load, prog_loaded_o pulses only after the 8th new byte.
